// File: rtl/liteeth_sram_fifo_ctrl.sv
// liteeth_sram_fifo_ctrl: valid/ready FIFO controller over a 1rw1r buffer SRAM macro
//    Writes go through the macro's rw0 port and reads through its r0 port. A 2-entry
//    output buffer hides the macro's 1-cycle registered read latency.
//    Ports:
//       clk_in, rst_n_in                   clock, asynchronous active-low reset
//       in_valid_in/in_ready_out/in_data_in    producer side
//       out_valid_out/out_ready_in/out_data_out consumer side (registered OB head)
//       level_out                          words held: SRAM + in-flight read + OB
//       sram_rw0_*                         macro write port (rd_out unused)
//       sram_r0_*                          macro read port, data valid the cycle after ce
module liteeth_sram_fifo_ctrl #(
   parameter int BITS       = 64,
   parameter int WORD_DEPTH = 1024,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  in_valid_in,
   output logic                  in_ready_out,
   input  logic [BITS-1:0]       in_data_in,
   output logic                  out_valid_out,
   input  logic                  out_ready_in,
   output logic [BITS-1:0]       out_data_out,
   output logic [ADDR_WIDTH+1:0] level_out,
   output logic                  sram_rw0_ce_out,
   output logic                  sram_rw0_we_out,
   output logic [ADDR_WIDTH-1:0] sram_rw0_addr_out,
   output logic [BITS-1:0]       sram_rw0_wd_out,
   output logic                  sram_r0_ce_out,
   output logic [ADDR_WIDTH-1:0] sram_r0_addr_out,
   input  logic [BITS-1:0]       sram_r0_rd_in
);
   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [ADDR_WIDTH:0]   mem_cnt;
   logic                  inflight;
   logic [1:0]            ob_cnt, wr_slot;
   logic [2:0]            ob_load;
   logic [BITS-1:0]       ob0, ob1, wd_hold;
   logic [ADDR_WIDTH+1:0] level;
   logic                  push, pop, issue;
   assign in_ready_out = mem_cnt != (ADDR_WIDTH+1)'(WORD_DEPTH);
   always_comb begin
      // gating with rst_n_in drops the write strobes as soon as reset asserts
      push    = in_valid_in & in_ready_out & rst_n_in;
      pop     = out_valid_out & out_ready_in;
      // OB occupancy after this edge if no new read is issued
      ob_load = {1'b0, ob_cnt} + {2'b0, inflight} - {2'b0, pop};
      issue   = (mem_cnt != '0) & (ob_load < 3'd2);
      // OB slot that an in-flight read lands in, after accounting for a pop
      wr_slot = ob_cnt - {1'b0, pop};
   end
   assign out_valid_out     = ob_cnt != 2'd0;
   assign out_data_out      = ob0;
   assign level_out         = level;
   assign sram_rw0_ce_out   = push;
   assign sram_rw0_we_out   = push;
   assign sram_rw0_addr_out = wr_ptr;
   assign sram_rw0_wd_out   = push ? in_data_in : wd_hold;
   assign sram_r0_ce_out    = issue;
   assign sram_r0_addr_out  = rd_ptr;
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         mem_cnt  <= '0;
         inflight <= 1'b0;
         ob_cnt   <= 2'd0;
         level    <= '0;
         wd_hold  <= '0;
         ob0      <= '0;
         ob1      <= '0;
      end else begin
         wr_ptr   <= wr_ptr + ADDR_WIDTH'(push);
         rd_ptr   <= rd_ptr + ADDR_WIDTH'(issue);
         mem_cnt  <= mem_cnt + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(issue);
         inflight <= issue;
         ob_cnt   <= ob_load[1:0];
         level    <= level + (ADDR_WIDTH+2)'(push) - (ADDR_WIDTH+2)'(pop);
         if (push) wd_hold <= in_data_in;
         // head keeps its value when the OB empties so out_data_out stays stable
         ob0 <= (inflight && wr_slot == 2'd0) ? sram_r0_rd_in :
                (pop && ob_cnt == 2'd2) ? ob1 : ob0;
         if (inflight && wr_slot == 2'd1) ob1 <= sram_r0_rd_in;
      end
   end
endmodule

// File: tb/tb_liteeth_sram_fifo_ctrl.sv
// tb_liteeth_sram_fifo_ctrl: directed and scoreboard bench for liteeth_sram_fifo_ctrl
module tb_liteeth_sram_fifo_ctrl;
   localparam int BITS = 64, DEPTH = 1024, AW = 10;
   logic            clk_in = 1'b0, rst_n_in = 1'b0, in_valid_in = 1'b0, out_ready_in = 1'b0;
   logic [BITS-1:0] in_data_in = '0;
   logic            in_ready_out, out_valid_out;
   logic [BITS-1:0] out_data_out, sram_rw0_wd_out, rd_q;
   logic [AW+1:0]   level_out;
   logic            sram_rw0_ce_out, sram_rw0_we_out, sram_r0_ce_out;
   logic [AW-1:0]   sram_rw0_addr_out, sram_r0_addr_out;
   logic [BITS-1:0] mem [DEPTH];
   always #5 clk_in = ~clk_in;
   liteeth_sram_fifo_ctrl #(.BITS(BITS), .WORD_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in),
      .in_valid_in(in_valid_in), .in_ready_out(in_ready_out), .in_data_in(in_data_in),
      .out_valid_out(out_valid_out), .out_ready_in(out_ready_in), .out_data_out(out_data_out),
      .level_out(level_out),
      .sram_rw0_ce_out(sram_rw0_ce_out), .sram_rw0_we_out(sram_rw0_we_out),
      .sram_rw0_addr_out(sram_rw0_addr_out), .sram_rw0_wd_out(sram_rw0_wd_out),
      .sram_r0_ce_out(sram_r0_ce_out), .sram_r0_addr_out(sram_r0_addr_out),
      .sram_r0_rd_in(rd_q)
   );
   // behavioural model of the 1rw1r macro with a registered read
   always @(posedge clk_in) begin
      if (sram_rw0_ce_out && sram_rw0_we_out) mem[sram_rw0_addr_out] <= sram_rw0_wd_out;
      if (sram_r0_ce_out) rd_q <= mem[sram_r0_addr_out];
   end
   int checks = 0, errors = 0;
   int rcvd, we_cnt, wraps, gaps, sent;
   bit sb_on, seen;
   logic [63:0] q [$];
   typedef struct {
      bit          iv, ord;
      logic [63:0] din;
      bit          ir, wce, rce, ov;
      logic [63:0] od;
      logic [11:0] lvl;
   } vec_t;
   vec_t tv [11];
   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask
   task automatic step(input bit iv, input bit ord, input logic [63:0] d);
      @(negedge clk_in);
      in_valid_in = iv; out_ready_in = ord; in_data_in = d;
      #1;
      if (sram_rw0_ce_out && sram_r0_ce_out) begin
         checks++;
         assert (sram_rw0_addr_out != sram_r0_addr_out) else begin
            errors++;
            $display("FAIL hazard: rw0 addr %h equals r0 addr %h", sram_rw0_addr_out, sram_r0_addr_out);
         end
      end
      if (sram_rw0_we_out) we_cnt++;
      if (sram_r0_ce_out && sram_r0_addr_out == AW'(DEPTH-1)) wraps++;
      if (sb_on) begin
         if (in_valid_in && in_ready_out) q.push_back(in_data_in);
         if (out_valid_out && out_ready_in) begin
            rcvd++;
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb_underflow: got %h expected no word", out_data_out);
            end else chk("sb_data", out_data_out, q.pop_front());
         end
      end
   endtask
   task automatic do_reset();
      @(negedge clk_in);
      rst_n_in = 1'b0; in_valid_in = 1'b0; out_ready_in = 1'b0;
      repeat (2) @(negedge clk_in);
      rst_n_in = 1'b1;
      q.delete();
   endtask
   initial begin
      logic [63:0] d = 64'hDEADBEEF_00000001, a = 64'h1111_2222_3333_4444, b = 64'h5555_6666_7777_8888;
      //            iv ord din ir wce rce ov od lvl
      tv[0]  = '{1'b1, 1'b0, d,   1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 12'd0};
      tv[1]  = '{1'b0, 1'b0, 0,   1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 12'd1};
      tv[2]  = '{1'b0, 1'b0, 0,   1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 12'd1};
      tv[3]  = '{1'b0, 1'b1, 0,   1'b1, 1'b0, 1'b0, 1'b1, d,     12'd1};
      tv[4]  = '{1'b0, 1'b0, 0,   1'b1, 1'b0, 1'b0, 1'b0, d,     12'd0};
      tv[5]  = '{1'b1, 1'b1, a,   1'b1, 1'b1, 1'b0, 1'b0, d,     12'd0};
      tv[6]  = '{1'b1, 1'b1, b,   1'b1, 1'b1, 1'b1, 1'b0, d,     12'd1};
      tv[7]  = '{1'b0, 1'b1, 0,   1'b1, 1'b0, 1'b1, 1'b0, d,     12'd2};
      tv[8]  = '{1'b0, 1'b1, 0,   1'b1, 1'b0, 1'b0, 1'b1, a,     12'd2};
      tv[9]  = '{1'b0, 1'b1, 0,   1'b1, 1'b0, 1'b0, 1'b1, b,     12'd1};
      tv[10] = '{1'b0, 1'b0, 0,   1'b1, 1'b0, 1'b0, 1'b0, b,     12'd0};
      sb_on = 1'b0;
      do_reset();
      for (int i = 0; i < 11; i++) begin
         step(tv[i].iv, tv[i].ord, tv[i].din);
         chk($sformatf("v%0d_in_ready", i), in_ready_out, tv[i].ir);
         chk($sformatf("v%0d_rw0_ce", i), sram_rw0_ce_out, tv[i].wce);
         chk($sformatf("v%0d_r0_ce", i), sram_r0_ce_out, tv[i].rce);
         chk($sformatf("v%0d_out_valid", i), out_valid_out, tv[i].ov);
         chk($sformatf("v%0d_out_data", i), out_data_out, tv[i].od);
         chk($sformatf("v%0d_level", i), level_out, tv[i].lvl);
      end
      // fill to full with the consumer stalled, then drain in order
      do_reset();
      sb_on = 1'b1; rcvd = 0; we_cnt = 0;
      for (int i = 0; i < 1100; i++) step(1'b1, 1'b0, 64'(i));
      step(1'b0, 1'b1, 64'd0);
      chk("fill_we_cnt", we_cnt, 1026);
      chk("fill_level", level_out, 1026);
      chk("fill_in_ready", in_ready_out, 0);
      chk("fill_head", out_data_out, 0);
      step(1'b0, 1'b0, 64'd0);
      chk("pop_in_ready", in_ready_out, 1);
      chk("pop_level", level_out, 1025);
      for (int i = 0; i < 3000 && rcvd < 1026; i++) step(1'b0, 1'b1, 64'd0);
      chk("drain_rcvd", rcvd, 1026);
      step(1'b0, 1'b0, 64'd0);
      chk("drain_level", level_out, 0);
      chk("drain_valid", out_valid_out, 0);
      // streaming at full rate
      rcvd = 0; wraps = 0; gaps = 0; seen = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         step(1'b1, 1'b1, 64'h100000 + 64'(i));
         if (seen && !out_valid_out) gaps++;
         if (out_valid_out) seen = 1'b1;
      end
      chk("stream_gaps", gaps, 0);
      chk("stream_rcvd", rcvd, 4997);
      chk("stream_wraps_ge4", wraps >= 4, 1);
      for (int i = 0; i < 20 && q.size() != 0; i++) step(1'b0, 1'b1, 64'd0);
      chk("stream_left", q.size(), 0);
      // random backpressure
      rcvd = 0; sent = 0;
      for (int i = 0; i < 40000 && rcvd < 10000; i++) begin
         bit iv;
         iv = sent < 10000 && $urandom_range(9) < 7;
         step(iv, $urandom_range(1) == 1, {$urandom, $urandom});
         if (iv && in_ready_out) sent++;
      end
      chk("rand_rcvd", rcvd, 10000);
      step(1'b0, 1'b0, 64'd0);
      chk("rand_level", level_out, 0);
      // asynchronous reset with words held
      do_reset();
      for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 64'(i));
      step(1'b0, 1'b0, 64'd0);
      chk("held_level", level_out, 300);
      chk("held_valid", out_valid_out, 1);
      @(negedge clk_in);
      in_valid_in = 1'b1;
      #3 rst_n_in = 1'b0;
      #1;
      chk("rst_valid", out_valid_out, 0);
      chk("rst_data", out_data_out, 0);
      chk("rst_level", level_out, 0);
      chk("rst_rw0_ce", sram_rw0_ce_out, 0);
      chk("rst_rw0_we", sram_rw0_we_out, 0);
      chk("rst_r0_ce", sram_r0_ce_out, 0);
      q.delete();
      @(negedge clk_in);
      rst_n_in = 1'b1; in_valid_in = 1'b0;
      rcvd = 0;
      step(1'b1, 1'b0, 64'hCAFE_F00D_0000_0042);
      chk("post_level", level_out, 0);
      step(1'b0, 1'b0, 64'd0);
      chk("post_r0_ce", sram_r0_ce_out, 1);
      step(1'b0, 1'b0, 64'd0);
      chk("post_valid_c2", out_valid_out, 0);
      step(1'b0, 1'b1, 64'd0);
      chk("post_valid_c3", out_valid_out, 1);
      chk("post_data_c3", out_data_out, 64'hCAFE_F00D_0000_0042);
      step(1'b0, 1'b0, 64'd0);
      chk("post_rcvd", rcvd, 1);
      chk("post_level_end", level_out, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
